// File: rtl/fixed_mac_accum.sv
// Fixed-point multiply-accumulate for the neuron datapath: Q-format products are
// rounded, saturated and summed onto a per-vector bias, one result per vector.
module fixed_mac_accum #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int RELU   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_act,
   input  logic [DATA_W-1:0] in_wgt,
   input  logic              in_last,
   input  logic [DATA_W-1:0] bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sat
);

   localparam logic [1:0] ST_ACC   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam int PW = 2 * DATA_W;
   localparam int RW = PW + 1;

   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [RW-1:0] HALF =
      {{(RW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

   logic [1:0] state;
   logic       first;
   logic       sticky;
   logic       accept;
   logic       out_fire;

   logic                     s0_valid, s0_last, s0_first;
   logic signed [DATA_W-1:0] s0_act, s0_wgt;
   logic        [DATA_W-1:0] s0_bias;

   logic                     s1_valid, s1_last, s1_first;
   logic signed [PW-1:0]     s1_p;
   logic        [DATA_W-1:0] s1_bias;

   logic [DATA_W-1:0] acc;

   logic signed [RW-1:0]     p_rnd;
   logic signed [RW-1:0]     r_wide;
   logic [RW-DATA_W:0]       r_hi;
   logic                     p_sat;
   logic [DATA_W-1:0]        r;
   logic [DATA_W-1:0]        base;
   logic [DATA_W:0]          sum;
   logic                     a_sat;
   logic [DATA_W-1:0]        s_sat;
   logic                     sticky_next;
   logic                     relu_zero;

   assign in_ready = (state == ST_ACC) && !rst;
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Round half up with a guard bit, then clamp to the result range; the bits above
   // the result's sign bit must all agree with it or the value is out of range.
   always_comb begin
      p_rnd  = RW'(s1_p) + HALF;
      r_wide = p_rnd >>> FRAC_W;
      r_hi   = r_wide[RW-1:DATA_W-1];
      p_sat  = !((&r_hi) || !(|r_hi));
      r      = p_sat ? (r_wide[RW-1] ? SAT_MIN : SAT_MAX) : r_wide[DATA_W-1:0];
   end

   // Two's-complement overflow shows as disagreement between the extended sign and
   // the result sign, which matches the same-sign-operands adder rule.
   always_comb begin
      base        = s1_first ? s1_bias : acc;
      sum         = {base[DATA_W-1], base} + {r[DATA_W-1], r};
      a_sat       = sum[DATA_W] ^ sum[DATA_W-1];
      s_sat       = a_sat ? (sum[DATA_W] ? SAT_MIN : SAT_MAX) : sum[DATA_W-1:0];
      sticky_next = (s1_first ? 1'b0 : sticky) | p_sat | a_sat;
      relu_zero   = (RELU != 0) && s_sat[DATA_W-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_ACC;
         first     <= 1'b1;
         sticky    <= 1'b0;
         s0_valid  <= 1'b0;
         s0_last   <= 1'b0;
         s0_first  <= 1'b0;
         s0_act    <= '0;
         s0_wgt    <= '0;
         s0_bias   <= '0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_first  <= 1'b0;
         s1_p      <= '0;
         s1_bias   <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         s0_valid <= accept;
         if (accept) begin
            s0_act   <= in_act;
            s0_wgt   <= in_wgt;
            s0_last  <= in_last;
            s0_first <= first;
            s0_bias  <= bias;
         end

         if (accept)
            first <= 1'b0;
         else if (out_fire)
            first <= 1'b1;

         s1_valid <= s0_valid;
         if (s0_valid) begin
            s1_p     <= PW'(s0_act) * PW'(s0_wgt);
            s1_last  <= s0_last;
            s1_first <= s0_first;
            s1_bias  <= s0_bias;
         end

         if (s1_valid) begin
            acc    <= s_sat;
            sticky <= sticky_next;
            if (s1_last) begin
               out_data  <= relu_zero ? '0 : s_sat;
               out_sat   <= sticky_next;
               out_valid <= 1'b1;
               state     <= ST_HOLD;
            end
         end

         if (state == ST_ACC && accept && in_last)
            state <= ST_DRAIN;

         if (state == ST_HOLD && out_fire) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
         end
      end
   end

endmodule

// File: tb/tb_fixed_mac_accum.sv
// Randomized and directed bench for fixed_mac_accum; a RELU=0 and a RELU=1 instance
// share one input stream and are both checked against an arithmetic reference model.
module tb_fixed_mac_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_act, in_wgt, bias;
   logic        in_last;
   logic        out_ready;
   logic        in_ready0, in_ready1;
   logic        out_valid0, out_valid1;
   logic [15:0] out_data0, out_data1;
   logic        out_sat0, out_sat1;

   int total = 0;
   int bad   = 0;

   logic [15:0] va[$];
   logic [15:0] vw[$];

   always #5 clk = ~clk;

   fixed_mac_accum #(.DATA_W(16), .FRAC_W(8), .RELU(0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last), .bias(bias),
      .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
      .out_sat(out_sat0)
   );

   fixed_mac_accum #(.DATA_W(16), .FRAC_W(8), .RELU(1)) dut_relu (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last), .bias(bias),
      .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
      .out_sat(out_sat1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint clip16(input longint v, inout bit sat);
      if (v > 32767) begin
         sat = 1'b1;
         return 32767;
      end
      if (v < -32768) begin
         sat = 1'b1;
         return -32768;
      end
      return v;
   endfunction

   // Neuron sum from plain integer arithmetic: floor((a*w + half)/256), clamp, add, clamp.
   task automatic model(input logic [15:0] b, input bit relu,
                        output logic [15:0] d, output logic s);
      longint a, p, r;
      bit     st;
      st = 1'b0;
      a  = longint'($signed(b));
      for (int i = 0; i < va.size(); i++) begin
         p = longint'($signed(va[i])) * longint'($signed(vw[i]));
         r = clip16((p + 128) >>> 8, st);
         a = clip16(a + r, st);
      end
      d = (relu && a < 0) ? 16'h0000 : a[15:0];
      s = st;
   endtask

   task automatic check_ready(input string tag, input logic exp);
      check_eq({tag, "_rdy0"}, in_ready0, exp);
      check_eq({tag, "_rdy1"}, in_ready1, exp);
   endtask

   task automatic check_valid(input string tag, input logic exp);
      check_eq({tag, "_vld0"}, out_valid0, exp);
      check_eq({tag, "_vld1"}, out_valid1, exp);
   endtask

   task automatic send_beat(input logic [15:0] a, input logic [15:0] w,
                            input logic [15:0] b, input logic is_first, input logic last);
      int n;
      n = 0;
      if ($urandom_range(0, 3) == 0) begin
         in_valid = 1'b0;
         in_act   = 16'($urandom);
         in_wgt   = 16'($urandom);
         in_last  = 1'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_act   = a;
      in_wgt   = w;
      in_last  = last;
      bias     = is_first ? b : 16'($urandom);
      while (!in_ready0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready0) check_eq("accept_timeout", in_ready0, 1'b1);
      @(negedge clk);
   endtask

   task automatic run_vec(input logic [15:0] b, input int stall);
      logic [15:0] e0, e1, d0, d1;
      logic        s0, s1;
      model(b, 1'b0, e0, s0);
      model(b, 1'b1, e1, s1);
      for (int i = 0; i < va.size(); i++)
         send_beat(va[i], vw[i], b, i == 0, i == va.size() - 1);
      // Junk with in_valid high while draining must be ignored.
      in_valid = 1'b1;
      in_act   = 16'($urandom);
      in_wgt   = 16'($urandom);
      in_last  = 1'b0;
      check_ready("drain", 1'b0);
      check_valid("lat1", 1'b0);
      @(negedge clk);
      check_valid("lat2", 1'b0);
      @(negedge clk);
      check_valid("lat_out", 1'b1);
      check_eq("data0", out_data0, e0);
      check_eq("data1", out_data1, e1);
      check_eq("sat0", out_sat0, s0);
      check_eq("sat1", out_sat1, s1);
      d0 = out_data0;
      d1 = out_data1;
      for (int k = 0; k < stall; k++) begin
         in_act = 16'($urandom);
         @(negedge clk);
         check_valid("hold", 1'b1);
         check_ready("hold", 1'b0);
         check_eq("hold_data0", out_data0, d0);
         check_eq("hold_data1", out_data1, d1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_valid("after_hs", 1'b0);
      check_ready("after_hs", 1'b1);
   endtask

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 2))
         0:       return 16'($urandom);
         1:       return 16'($urandom_range(0, 16'h0600)) - 16'h0300;
         default: return 16'h7000 + 16'($urandom_range(0, 16'h1FFF));
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_act    = '0;
      in_wgt    = '0;
      in_last   = 1'b0;
      bias      = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_ready("reset", 1'b0);
      check_valid("reset", 1'b0);
      check_eq("reset_data", out_data0, 16'h0000);
      check_eq("reset_sat", out_sat0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_ready("post_reset", 1'b1);

      va = '{16'h0100, 16'h0080}; vw = '{16'h0200, 16'h0400}; run_vec(16'h0000, 0);
      va = '{16'h0001}; vw = '{16'h0080}; run_vec(16'h0000, 0);
      va = '{16'h0001}; vw = '{16'h007F}; run_vec(16'h0000, 1);
      va = '{16'hFFFF}; vw = '{16'h0080}; run_vec(16'h0000, 0);
      va = '{16'hFFFF}; vw = '{16'h0081}; run_vec(16'h0000, 0);
      va = '{16'h0100}; vw = '{16'h2000}; run_vec(16'h7000, 0);
      va = '{16'h7FFF}; vw = '{16'h7FFF}; run_vec(16'h0000, 0);
      va = '{16'h0100}; vw = '{16'hF000}; run_vec(16'h8000, 0);
      va = '{16'h0100}; vw = '{16'hFF00}; run_vec(16'h0000, 2);
      va = '{16'h0100, 16'h0100}; vw = '{16'h0300, 16'h0100}; run_vec(16'h0000, 5);
      va = '{16'h0100}; vw = '{16'h0100}; run_vec(16'h0100, 0);

      // Reset with two beats of a four-beat vector in flight.
      send_beat(16'h0200, 16'h0300, 16'h0500, 1'b1, 1'b0);
      send_beat(16'h0100, 16'h0400, 16'h0000, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check_ready("mid_rst", 1'b0);
      check_valid("mid_rst", 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_valid("no_out_after_rst", 1'b0);
      end
      va = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
      vw = '{16'h0100, 16'h0100, 16'h0100, 16'h0200};
      run_vec(16'h0040, 0);

      for (int t = 0; t < 40; t++) begin
         int len;
         len = $urandom_range(1, 6);
         va.delete();
         vw.delete();
         for (int i = 0; i < len; i++) begin
            va.push_back(rnd16());
            vw.push_back(rnd16());
         end
         run_vec(rnd16(), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
